// File: rtl/stopwatch_lap_if.sv
// stopwatch_lap_if: control inputs and display/lap outputs of the stopwatch.
//   master : debouncer / display side (drives controls, reads time and laps)
//   slave  : stopwatch_lap core
// Controls: Start_S, Stop_S, Reset_S, Lap_S (levels, rising edge acts), Lap_Rd (pop pulse).
// Outputs:  running time, Running, Overflow, lap FIFO head and occupancy.
interface stopwatch_lap_if #(
  parameter int HOURS_W = 4,
  parameter int LAP_AW  = 2
);
  logic               Start_S;
  logic               Stop_S;
  logic               Reset_S;
  logic               Lap_S;
  logic               Lap_Rd;
  logic [HOURS_W-1:0] Hours_S;
  logic [5:0]         Mins_S;
  logic [5:0]         Secs_S;
  logic [9:0]         MSecs_S;
  logic               Running;
  logic               Overflow;
  logic               Lap_Valid;
  logic [HOURS_W-1:0] Lap_Hours;
  logic [5:0]         Lap_Mins;
  logic [5:0]         Lap_Secs;
  logic [9:0]         Lap_MSecs;
  logic [LAP_AW:0]    Lap_Count;
  logic               Lap_Full;

  modport master (
    output Start_S, Stop_S, Reset_S, Lap_S, Lap_Rd,
    input  Hours_S, Mins_S, Secs_S, MSecs_S, Running, Overflow, Lap_Valid,
           Lap_Hours, Lap_Mins, Lap_Secs, Lap_MSecs, Lap_Count, Lap_Full
  );

  modport slave (
    input  Start_S, Stop_S, Reset_S, Lap_S, Lap_Rd,
    output Hours_S, Mins_S, Secs_S, MSecs_S, Running, Overflow, Lap_Valid,
           Lap_Hours, Lap_Mins, Lap_Secs, Lap_MSecs, Lap_Count, Lap_Full
  );
endinterface

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: HH:MM:SS.mmm stopwatch with run/pause/clear and a lap FIFO.
// Ports:
//   Clock_1MSec  system clock, rising edge
//   Reset        asynchronous active-high reset
//   bus          stopwatch_lap_if.slave (controls in; time, status and lap head out)
//
// state  | meaning
// IDLE   | cleared, waiting for Start
// RUN    | prescaler and time advancing, laps captured
// PAUSED | time frozen (Stop or saturation), Start resumes unless Overflow
module stopwatch_lap #(
  parameter int TICK_DIV  = 1,
  parameter int HOURS_W   = 4,
  parameter int HOURS_MAX = 15,
  parameter int LAP_DEPTH = 4,
  parameter int LAP_AW    = 2
) (
  input logic           Clock_1MSec,
  input logic           Reset,
  stopwatch_lap_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = HOURS_W + 22;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t             state_q, state_d;
  logic [3:0]         sync_q, prev_q;   // {lap, start, stop, clear}
  logic [3:0]         edge_v;
  logic               clr_e, stop_e, start_e, lap_e;
  logic [PW-1:0]      presc_q;
  logic [HOURS_W-1:0] hours_q;
  logic [5:0]         mins_q, secs_q;
  logic [9:0]         msecs_q;
  logic               overflow_q;
  logic               tick, at_max, sat, capture, push, pop;
  logic [TW-1:0]      mem [LAP_DEPTH];
  logic [LAP_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LAP_AW:0]    count_q;
  logic [TW-1:0]      head;

  assign edge_v  = sync_q & ~prev_q;
  assign clr_e   = edge_v[0];
  assign stop_e  = edge_v[1];
  assign start_e = edge_v[2];
  assign lap_e   = edge_v[3];

  assign tick   = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
  assign at_max = (hours_q == HOURS_W'(HOURS_MAX)) && (mins_q == 6'd59) &&
                  (secs_q == 6'd59) && (msecs_q == 10'd999);
  assign sat    = tick && at_max;

  // Only the highest-priority edge of a cycle acts; lower ones are discarded.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (clr_e) begin
      state_d = IDLE;
    end else if (stop_e) begin
      if (state_q == RUN) state_d = PAUSED;
    end else if (start_e) begin
      if (state_q != RUN && !overflow_q) state_d = RUN;
    end else if (lap_e && state_q == RUN) begin
      capture = 1'b1;
    end
    if (!clr_e && sat) state_d = PAUSED;
  end

  always_ff @(posedge Clock_1MSec or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {bus.Lap_S, bus.Start_S, bus.Stop_S, bus.Reset_S};
      prev_q  <= sync_q;
    end
  end

  always_ff @(posedge Clock_1MSec or posedge Reset) begin
    if (Reset) begin
      presc_q    <= '0;
      hours_q    <= '0;
      mins_q     <= '0;
      secs_q     <= '0;
      msecs_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clr_e) begin
      presc_q    <= '0;
      hours_q    <= '0;
      mins_q     <= '0;
      secs_q     <= '0;
      msecs_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (state_q == RUN) presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (at_max) begin
          overflow_q <= 1'b1;
        end else if (msecs_q != 10'd999) begin
          msecs_q <= msecs_q + 10'd1;
        end else begin
          msecs_q <= '0;
          if (secs_q != 6'd59) begin
            secs_q <= secs_q + 6'd1;
          end else begin
            secs_q <= '0;
            if (mins_q != 6'd59) begin
              mins_q <= mins_q + 6'd1;
            end else begin
              mins_q  <= '0;
              hours_q <= hours_q + HOURS_W'(1);
            end
          end
        end
      end
    end
  end

  // A pop frees a slot, so a capture into a full FIFO still lands when popped together.
  assign pop  = bus.Lap_Rd && (count_q != '0) && !clr_e;
  assign push = capture && ((count_q != (LAP_AW+1)'(LAP_DEPTH)) || pop);

  always_ff @(posedge Clock_1MSec) begin
    if (push) mem[wr_ptr_q] <= {hours_q, mins_q, secs_q, msecs_q};
  end

  always_ff @(posedge Clock_1MSec or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_e) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr_q];

  assign bus.Hours_S   = hours_q;
  assign bus.Mins_S    = mins_q;
  assign bus.Secs_S    = secs_q;
  assign bus.MSecs_S   = msecs_q;
  assign bus.Running   = (state_q == RUN);
  assign bus.Overflow  = overflow_q;
  assign bus.Lap_Valid = (count_q != '0);
  assign bus.Lap_Full  = (count_q == (LAP_AW+1)'(LAP_DEPTH));
  assign bus.Lap_Count = count_q;
  assign {bus.Lap_Hours, bus.Lap_Mins, bus.Lap_Secs, bus.Lap_MSecs} = head;
endmodule

// File: tb/tb_stopwatch_lap.sv
// tb_stopwatch_lap: two stopwatch_lap instances (TICK_DIV=1/HOURS_MAX=0 and
// TICK_DIV=4/HOURS_MAX=15) driven by the same controls, checked every cycle
// against a millisecond-count model, plus directed literal checks.
module tb_stopwatch_lap;
  localparam int NI = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ctl;   // {lap, start, stop, clear}
  logic       rd;
  bit         preload;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  stopwatch_lap_if #(.HOURS_W(4), .LAP_AW(2)) if0 ();
  stopwatch_lap_if #(.HOURS_W(4), .LAP_AW(2)) if1 ();

  assign if0.Reset_S = ctl[0];
  assign if0.Stop_S  = ctl[1];
  assign if0.Start_S = ctl[2];
  assign if0.Lap_S   = ctl[3];
  assign if0.Lap_Rd  = rd;
  assign if1.Reset_S = ctl[0];
  assign if1.Stop_S  = ctl[1];
  assign if1.Start_S = ctl[2];
  assign if1.Lap_S   = ctl[3];
  assign if1.Lap_Rd  = rd;

  stopwatch_lap #(.TICK_DIV(1), .HOURS_W(4), .HOURS_MAX(0), .LAP_DEPTH(4), .LAP_AW(2))
    u0 (.Clock_1MSec(clk), .Reset(rst), .bus(if0));
  stopwatch_lap #(.TICK_DIV(4), .HOURS_W(4), .HOURS_MAX(15), .LAP_DEPTH(4), .LAP_AW(2))
    u1 (.Clock_1MSec(clk), .Reset(rst), .bus(if1));

  logic [25:0] d_time [NI];
  logic [25:0] d_lap  [NI];
  logic [6:0]  d_stat [NI];   // {Running, Overflow, Lap_Valid, Lap_Full, Lap_Count}

  assign d_time[0] = {if0.Hours_S, if0.Mins_S, if0.Secs_S, if0.MSecs_S};
  assign d_time[1] = {if1.Hours_S, if1.Mins_S, if1.Secs_S, if1.MSecs_S};
  assign d_lap[0]  = {if0.Lap_Hours, if0.Lap_Mins, if0.Lap_Secs, if0.Lap_MSecs};
  assign d_lap[1]  = {if1.Lap_Hours, if1.Lap_Mins, if1.Lap_Secs, if1.Lap_MSecs};
  assign d_stat[0] = {if0.Running, if0.Overflow, if0.Lap_Valid, if0.Lap_Full, if0.Lap_Count};
  assign d_stat[1] = {if1.Running, if1.Overflow, if1.Lap_Valid, if1.Lap_Full, if1.Lap_Count};

  // Model: elapsed time as a plain millisecond count, laps as a queue.
  int       m_state [NI];   // 0 idle, 1 run, 2 paused
  int       m_t     [NI];
  int       m_pre   [NI];
  bit       m_ovf   [NI];
  int       m_fifo  [NI][$];
  bit [3:0] h1, h2;

  function automatic int tdiv(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int tmax(int i);
    return ((i == 0) ? 1 : 16) * 3600000 - 1;
  endfunction

  function automatic logic [25:0] split(int t);
    logic [3:0] h;
    logic [5:0] m, s;
    logic [9:0] ms;
    h  = 4'(t / 3600000);
    m  = 6'((t / 60000) % 60);
    s  = 6'((t / 1000) % 60);
    ms = 10'(t % 1000);
    return {h, m, s, ms};
  endfunction

  function automatic logic [25:0] lit(int h, int m, int s, int ms);
    return {4'(h), 6'(m), 6'(s), 10'(ms)};
  endfunction

  task automatic chk(string nm, int i, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic model_reset(int i);
    m_state[i] = 0;
    m_t[i]     = 0;
    m_pre[i]   = 0;
    m_ovf[i]   = 1'b0;
    m_fifo[i].delete();
  endtask

  task automatic model_step();
    bit [3:0] ev;
    bit       tick, cap, pop;
    int       cur, old;
    if (rst) begin
      h1 = '0;
      h2 = '0;
      for (int i = 0; i < NI; i++) model_reset(i);
      return;
    end
    ev = h1 & ~h2;
    for (int i = 0; i < NI; i++) begin
      cur  = m_state[i];
      old  = m_t[i];
      tick = (cur == 1) && (m_pre[i] == tdiv(i) - 1);
      cap  = 1'b0;
      if (ev[0]) begin
        model_reset(i);
        continue;
      end
      if (ev[1]) begin
        if (cur == 1) m_state[i] = 2;
      end else if (ev[2]) begin
        if (cur != 1 && !m_ovf[i]) m_state[i] = 1;
      end else if (ev[3] && cur == 1) begin
        cap = 1'b1;
      end
      pop = rd && (m_fifo[i].size() > 0);
      if (cur == 1) m_pre[i] = tick ? 0 : m_pre[i] + 1;
      if (tick) begin
        if (m_t[i] == tmax(i)) begin
          m_ovf[i]   = 1'b1;
          m_state[i] = 2;
        end else begin
          m_t[i] = m_t[i] + 1;
        end
      end
      if (pop) void'(m_fifo[i].pop_front());
      if (cap && m_fifo[i].size() < 4) m_fifo[i].push_back(old);
    end
    if (preload) m_t[0] = 3599990;
    h2 = h1;
    h1 = ctl;
  endtask

  task automatic compare();
    logic [6:0] st;
    int         n;
    for (int i = 0; i < NI; i++) begin
      n  = m_fifo[i].size();
      st = {m_state[i] == 1, m_ovf[i], n > 0, n == 4, 3'(n)};
      chk("time", i, d_time[i], split(m_t[i]));
      chk("status", i, d_stat[i], st);
      if (n > 0) chk("lap_head", i, d_lap[i], split(m_fifo[i][0]));
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    compare();
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int k);
    ctl[k] = 1'b1;
    @(negedge clk);
    ctl[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ctl = '0; rd = 1'b0; preload = 1'b0;
    cyc(3);
    chk("reset_time", 0, d_time[0], lit(0, 0, 0, 0));
    chk("reset_stat", 1, d_stat[1], 7'd0);
    rst = 1'b0;

    // start, 1.5 s run
    press(2);
    cyc(1);
    chk("start_running", 0, if0.Running, 1);
    chk("start_time", 0, d_time[0], lit(0, 0, 0, 0));
    cyc(40);
    chk("div4_40cyc", 1, d_time[1], lit(0, 0, 0, 10));
    cyc(1460);
    chk("run_1500", 0, d_time[0], lit(0, 0, 1, 500));
    chk("div4_1500", 1, d_time[1], lit(0, 0, 0, 375));

    // stop mid-prescale, hold, resume
    press(1);
    cyc(100);
    chk("frozen", 0, d_time[0], lit(0, 0, 1, 502));
    chk("frozen_run", 0, if0.Running, 0);
    chk("frozen_div4", 1, d_time[1], lit(0, 0, 0, 375));
    press(2);
    cyc(1);
    chk("resume_running", 1, if1.Running, 1);
    cyc(1);
    chk("resume_presc_a", 1, d_time[1], lit(0, 0, 0, 375));
    cyc(1);
    chk("resume_presc_b", 1, d_time[1], lit(0, 0, 0, 376));
    chk("resume_exact", 0, d_time[0], lit(0, 0, 1, 504));

    // lap FIFO fill, overflow drop, drain
    press(0);
    press(2);
    cyc(10);
    for (int k = 0; k < 5; k++) begin
      press(3);
      cyc(3);
    end
    chk("lap_count_full", 0, if0.Lap_Count, 4);
    chk("lap_full", 1, if1.Lap_Full, 1);
    for (int k = 0; k < 4; k++) begin
      chk("lap_order", 0, d_lap[0], lit(0, 0, 0, 10 + 4 * k));
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
    end
    chk("lap_drained", 0, if0.Lap_Valid, 0);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    chk("lap_empty_pop", 1, if1.Lap_Count, 0);

    // full FIFO: capture and pop in the same action cycle
    for (int k = 0; k < 4; k++) begin
      press(3);
      cyc(3);
    end
    ctl[3] = 1'b1;
    @(negedge clk);
    ctl[3] = 1'b0;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    chk("push_pop_full", 0, if0.Lap_Count, 4);
    chk("push_pop_full", 1, if1.Lap_Count, 4);
    cyc(2);

    // clear beats stop and start
    ctl[2:0] = 3'b111;
    @(negedge clk);
    ctl = '0;
    @(negedge clk);
    chk("coinc_clear_stat", 0, d_stat[0], 7'd0);
    chk("coinc_clear_time", 1, d_time[1], lit(0, 0, 0, 0));

    // stop+start together while paused
    press(2);
    cyc(5);
    press(1);
    cyc(2);
    ctl[2:1] = 2'b11;
    @(negedge clk);
    ctl = '0;
    cyc(2);
    chk("paused_stays", 0, if0.Running, 0);
    chk("paused_stays", 1, if1.Running, 0);

    // saturation at HOURS_MAX=0 on u0, preloaded near the top
    force u0.hours_q = 4'd0;
    force u0.mins_q  = 6'd59;
    force u0.secs_q  = 6'd59;
    force u0.msecs_q = 10'd990;
    preload = 1'b1;
    @(negedge clk);
    release u0.hours_q;
    release u0.mins_q;
    release u0.secs_q;
    release u0.msecs_q;
    preload = 1'b0;
    press(2);
    cyc(20);
    chk("sat_time", 0, d_time[0], lit(0, 59, 59, 999));
    chk("sat_ovf", 0, if0.Overflow, 1);
    chk("sat_running", 0, if0.Running, 0);
    press(2);
    cyc(3);
    chk("sat_start_ignored", 0, if0.Running, 0);
    press(0);
    cyc(1);
    chk("sat_clear_stat", 0, d_stat[0], 7'd0);
    chk("sat_clear_time", 0, d_time[0], lit(0, 0, 0, 0));

    // async reset mid-count
    press(2);
    cyc(50);
    rst = 1'b1;
    #1;
    chk("async_time", 0, d_time[0], lit(0, 0, 0, 0));
    chk("async_time", 1, d_time[1], lit(0, 0, 0, 0));
    chk("async_running", 0, if0.Running, 0);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      ctl[0] = ($urandom_range(0, 199) == 0);
      ctl[1] = ($urandom_range(0, 99) < 4);
      ctl[2] = ($urandom_range(0, 99) < 10);
      ctl[3] = ($urandom_range(0, 99) < 15);
      rd     = ($urandom_range(0, 99) < 12);
      rst    = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    ctl = '0; rd = 1'b0; rst = 1'b0;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
